// File: rtl/hdmi_sysid_pkg.sv
// Shared types and constants for the HDMI system-ID checker.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hdmi_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int TO_W    = 8;
    localparam int RETRY_W = 2;

endpackage

// File: rtl/hdmi_sysid_rd_lat.sv
// Turns the Avalon read-accept pulse into a readdata capture strobe.
// Latency: READ_LATENCY cycles (0 = combinational pass-through).
// Backpressure: none; one strobe per accept, no flow control.
//
// Ports: clock, reset_n (async active-low), accept (read accepted this
// cycle), capture (readdata valid this cycle).
module hdmi_sysid_rd_lat #(
    parameter int READ_LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic accept,
    output logic capture
);

    generate
        if (READ_LATENCY == 0) begin : g_comb
            assign capture = accept;
        end else begin : g_pipe
            logic [READ_LATENCY-1:0] pipe_q;
            logic [READ_LATENCY-1:0] pipe_d;

            always_comb begin
                pipe_d    = pipe_q << 1;
                pipe_d[0] = accept;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign capture = pipe_q[READ_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/hdmi_sysid_checker.sv
// Reads system-ID word (addr 0) and timestamp (addr 1) over Avalon-MM and
// compares them with build-time values. Latency: ~6 cycles per check at
// READ_LATENCY=1 with no stalls. Backpressure: holds avm_read/address
// through waitrequest; a per-read timeout with retries aborts a dead slave.
//
// Ports: clock, reset_n (async active-low), start (rerun request),
// avm_* (Avalon-MM read master), id_value/timestamp_value (last words read),
// busy, done, id_match, ts_match, error (retries exhausted).
// Optional: define HDMI_SYSID_PERIODIC_EN to re-run the check every
// RECHECK_PERIOD cycles while in PASS.
module hdmi_sysid_checker
    import hdmi_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1539181415,
    parameter int          READ_LATENCY       = 1,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3,
    parameter int          AUTO_START         = 1
`ifdef HDMI_SYSID_PERIODIC_EN
    ,
    parameter int          RECHECK_PERIOD     = 1 << 24
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        error
);

    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                avm_read_q, avm_read_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [31:0]         id_value_q, id_value_d;
    logic [31:0]         ts_value_q, ts_value_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                id_match_q, id_match_d;
    logic                ts_match_q, ts_match_d;
    logic                error_q, error_d;
    logic                auto_pend_q, auto_pend_d;

`ifdef HDMI_SYSID_PERIODIC_EN
    localparam logic [23:0] PER_LAST = 24'(RECHECK_PERIOD - 1);
    logic [23:0]         per_cnt_q, per_cnt_d;
`endif

    logic rd_accept;
    logic rd_capture;
    logic do_cap;
    logic kick;
    logic kick_clear;

    assign rd_accept = avm_read_q && !avm_waitrequest;

    hdmi_sysid_rd_lat #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_lat (
        .clock   (clock),
        .reset_n (reset_n),
        .accept  (rd_accept),
        .capture (rd_capture)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        avm_read_d  = avm_read_q;
        to_cnt_d    = to_cnt_q;
        retry_d     = retry_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        done_d      = done_q;
        id_match_d  = id_match_q;
        ts_match_d  = ts_match_q;
        error_d     = error_q;
        // One-shot: only the first cycle after reset release may auto-start.
        auto_pend_d = 1'b0;
        do_cap      = 1'b0;
        kick        = 1'b0;
        kick_clear  = 1'b0;
`ifdef HDMI_SYSID_PERIODIC_EN
        per_cnt_d   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start || auto_pend_q) begin
                    kick       = 1'b1;
                    kick_clear = 1'b1;
                end
            end

            ST_REQ: begin
                if (avm_read_q) begin
                    if (rd_accept) begin
                        avm_read_d = 1'b0;
                        // Zero-latency slaves present data in the accept cycle.
                        if (rd_capture) begin
                            do_cap = 1'b1;
                        end else begin
                            state_d  = ST_WAIT;
                            to_cnt_d = to_cnt_q + 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        avm_read_d = 1'b0;
                        if (retry_q >= RETRY_LAST) begin
                            state_d = ST_FAIL;
                            error_d = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            retry_d = retry_q + 1'b1;
                        end
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    // Retry after a timeout: one idle cycle, then re-issue.
                    avm_read_d = 1'b1;
                    to_cnt_d   = '0;
                end
            end

            ST_WAIT: begin
                if (rd_capture) begin
                    do_cap = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            ST_CHECK: begin
                id_match_d = (id_value_q == EXPECTED_ID);
                ts_match_d = (ts_value_q == EXPECTED_TIMESTAMP);
                done_d     = 1'b1;
                if ((id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TIMESTAMP)) begin
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_FAIL;
                end
            end

            ST_PASS: begin
                if (start) begin
                    kick       = 1'b1;
                    kick_clear = 1'b1;
                end
`ifdef HDMI_SYSID_PERIODIC_EN
                // Periodic recheck keeps done and the old flags visible.
                else if (per_cnt_q == PER_LAST) begin
                    kick = 1'b1;
                end else begin
                    per_cnt_d = per_cnt_q + 24'd1;
                end
`endif
            end

            ST_FAIL: begin
                if (start) begin
                    kick       = 1'b1;
                    kick_clear = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_cap) begin
            retry_d = '0;
            if (sel_q == SYSID_ADDR_ID) begin
                id_value_d = avm_readdata;
                state_d    = ST_REQ;
                sel_d      = SYSID_ADDR_TS;
                avm_read_d = 1'b1;
                to_cnt_d   = '0;
            end else begin
                ts_value_d = avm_readdata;
                state_d    = ST_CHECK;
            end
        end

        if (kick) begin
            state_d    = ST_REQ;
            sel_d      = SYSID_ADDR_ID;
            avm_read_d = 1'b1;
            to_cnt_d   = '0;
            retry_d    = '0;
        end

        if (kick_clear) begin
            done_d     = 1'b0;
            error_d    = 1'b0;
            id_match_d = 1'b0;
            ts_match_d = 1'b0;
        end

        busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= SYSID_ADDR_ID;
            avm_read_q  <= 1'b0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
            id_value_q  <= '0;
            ts_value_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            id_match_q  <= 1'b0;
            ts_match_q  <= 1'b0;
            error_q     <= 1'b0;
            auto_pend_q <= (AUTO_START != 0);
`ifdef HDMI_SYSID_PERIODIC_EN
            per_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            avm_read_q  <= avm_read_d;
            to_cnt_q    <= to_cnt_d;
            retry_q     <= retry_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            id_match_q  <= id_match_d;
            ts_match_q  <= ts_match_d;
            error_q     <= error_d;
            auto_pend_q <= auto_pend_d;
`ifdef HDMI_SYSID_PERIODIC_EN
            per_cnt_q   <= per_cnt_d;
`endif
        end
    end

    assign avm_read        = avm_read_q;
    assign avm_address     = sel_q;
    assign id_value        = id_value_q;
    assign timestamp_value = ts_value_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign id_match        = id_match_q;
    assign ts_match        = ts_match_q;
    assign error           = error_q;

endmodule

// File: tb/tb_hdmi_sysid_checker.sv
// Bench for hdmi_sysid_checker: fixed-latency Avalon slave model, per-cycle
// protocol/capture checker, and end-of-check outcome checks.
module tb_hdmi_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1539181415;
    localparam int LAT  = 1;
    localparam int TMO  = 255;
    localparam int MAXR = 3;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata    = 32'd0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] id_value;
    logic [31:0] timestamp_value;
    logic        busy, done, id_match, ts_match, error;

    always #5 clock = ~clock;

    hdmi_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .READ_LATENCY       (LAT),
        .TIMEOUT_CYCLES     (TMO),
        .MAX_RETRIES        (MAXR),
        .AUTO_START         (1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .id_value        (id_value),
        .timestamp_value (timestamp_value),
        .busy            (busy),
        .done            (done),
        .id_match        (id_match),
        .ts_match        (ts_match),
        .error           (error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [31:0] mem_id  = EXP_ID;
    logic [31:0] mem_ts  = EXP_TS;
    int          wr_mode = 0;      // 0 ready, 1 random stalls, 2 stuck
    int          stall_left = 0;   // stall cycles applied to the next request

    initial begin : slave
        bit   acc;
        logic a;
        forever begin
            @(negedge clock);
            acc = reset_n && avm_read && !avm_waitrequest;
            a   = avm_address;
            @(posedge clock);
            #1;
            // Data is valid exactly LAT cycles after accept; garbage otherwise.
            if (acc) avm_readdata = a ? mem_ts : mem_id;
            else     avm_readdata = $urandom;
            if (wr_mode == 2) begin
                avm_waitrequest = 1'b1;
            end else if (avm_read && stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else if (avm_read && wr_mode == 1) begin
                avm_waitrequest = ($urandom_range(0, 3) == 0);
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare process ----------------
    bit          prev_rd = 0, prev_wr = 0;
    logic        prev_addr = 0;
    int          stall_run = 0;
    int          cap_due = 0;
    logic        cap_addr = 0;
    logic [31:0] cap_val = 0;
    int          rd_hi = 0, rd_att = 0;
    bit          acc_log[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_rd   = 0;
            prev_wr   = 0;
            stall_run = 0;
            cap_due   = 0;
        end else begin
            if (prev_rd && prev_wr) begin
                if (stall_run >= TMO) begin
                    chk("timeout_drop", avm_read, 0);
                end else begin
                    chk("hold_read", avm_read, 1);
                    chk("hold_addr", avm_address, prev_addr);
                end
            end
            if (cap_due > 0) begin
                cap_due--;
                if (cap_due == 0) begin
                    if (cap_addr == 1'b0) chk("cap_id", id_value, cap_val);
                    else                  chk("cap_ts", timestamp_value, cap_val);
                end
            end
            chk("busy_done_excl", busy && done, 0);
            chk("error_implies_done", error && !done, 0);
            if (avm_read) begin
                rd_hi++;
                if (!prev_rd) rd_att++;
            end
            if (avm_read && !avm_waitrequest) begin
                acc_log.push_back(avm_address);
                cap_due  = LAT + 1;
                cap_addr = avm_address;
                cap_val  = avm_address ? mem_ts : mem_id;
            end
            stall_run = (avm_read && avm_waitrequest) ? ((prev_rd && prev_wr) ? stall_run + 1 : 1) : 0;
            prev_rd   = avm_read;
            prev_wr   = avm_waitrequest;
            prev_addr = avm_address;
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic pulse_start;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        chk({name, ".done_in_time"}, done, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".avm_read"}, avm_read, 0);
        chk({tag, ".avm_address"}, avm_address, 0);
        chk({tag, ".id_value"}, id_value, 0);
        chk({tag, ".timestamp_value"}, timestamp_value, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".id_match"}, id_match, 0);
        chk({tag, ".ts_match"}, ts_match, 0);
        chk({tag, ".error"}, error, 0);
    endtask

    // Outcome model: one ID read then one timestamp read, flags from compare.
    task automatic check_result(input string name, input logic [31:0] id, input logic [31:0] ts,
                                input int base);
        int n;
        n = acc_log.size() - base;
        chk({name, ".done"}, done, 1);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".error"}, error, 0);
        chk({name, ".avm_read"}, avm_read, 0);
        chk({name, ".id_value"}, id_value, id);
        chk({name, ".timestamp_value"}, timestamp_value, ts);
        chk({name, ".id_match"}, id_match, (id == EXP_ID));
        chk({name, ".ts_match"}, ts_match, (ts == EXP_TS));
        chk({name, ".num_reads"}, n, 2);
        if (n >= 2) begin
            chk({name, ".addr0"}, acc_log[base], 0);
            chk({name, ".addr1"}, acc_log[base+1], 1);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, base, rh, ra;
        bit extra;
        string nm;

        #1 reset_n = 1'b0;
        #20;
        chk_all_zero("reset");

        // T1: auto-start after reset, all matching
        @(negedge clock);
        reset_n = 1'b1;
        wait_done("t1", 20, cyc);
        chk("t1.latency_le_6", (cyc <= 6), 1);
        check_result("t1", EXP_ID, EXP_TS, 0);
        chk("t1.id_match_lit", id_match, 1);
        chk("t1.ts_match_lit", ts_match, 1);

        // T2: wrong ID
        mem_id = 32'h0000_0005;
        base = acc_log.size();
        pulse_start();
        wait_done("t2", 40, cyc);
        check_result("t2", 32'h5, EXP_TS, base);
        chk("t2.id_value_lit", id_value, 32'h0000_0005);
        chk("t2.id_match_lit", id_match, 0);
        chk("t2.ts_match_lit", ts_match, 1);

        // T3: 10 stall cycles on the ID read
        mem_id = EXP_ID;
        stall_left = 10;
        base = acc_log.size();
        rh = rd_hi;
        pulse_start();
        wait_done("t3", 60, cyc);
        check_result("t3", EXP_ID, EXP_TS, base);
        chk("t3.read_high_cycles", rd_hi - rh, 12);

        // T4: slave stuck in waitrequest
        wr_mode = 2;
        rh = rd_hi;
        ra = rd_att;
        pulse_start();
        wait_done("t4", 1200, cyc);
        chk("t4.error", error, 1);
        chk("t4.done", done, 1);
        chk("t4.busy", busy, 0);
        chk("t4.avm_read", avm_read, 0);
        chk("t4.id_match", id_match, 0);
        chk("t4.ts_match", ts_match, 0);
        chk("t4.attempts", rd_att - ra, 4);
        chk("t4.read_high_cycles", rd_hi - rh, 4 * TMO);
        wr_mode = 0;
        @(negedge clock);
        base = acc_log.size();
        pulse_start();
        chk("t4r.error_cleared", error, 0);
        wait_done("t4r", 40, cyc);
        check_result("t4r", EXP_ID, EXP_TS, base);

        // T5: start while busy is ignored, start after PASS reruns
        base = acc_log.size();
        pulse_start();
        @(negedge clock);
        chk("t5.busy_mid", busy, 1);
        pulse_start();
        wait_done("t5a", 40, cyc);
        check_result("t5a", EXP_ID, EXP_TS, base);
        base = acc_log.size();
        pulse_start();
        chk("t5b.done_cleared", done, 0);
        chk("t5b.id_match_cleared", id_match, 0);
        chk("t5b.busy", busy, 1);
        wait_done("t5b", 40, cyc);
        check_result("t5b", EXP_ID, EXP_TS, base);

        // T6: reset during WAIT
        pulse_start();
        for (int i = 0; i < 20 && !(avm_read && !avm_waitrequest && avm_address == 1'b0); i++)
            @(negedge clock);
        chk("t6.id_accept_seen", (avm_read && !avm_waitrequest && avm_address == 1'b0), 1);
        @(negedge clock);
        chk("t6.busy_in_wait", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("t6.async_reset");
        repeat (2) @(negedge clock);
        base = acc_log.size();
        reset_n = 1'b1;
        wait_done("t6", 20, cyc);
        check_result("t6", EXP_ID, EXP_TS, base);

        // Randomized checks
        for (int it = 0; it < 24; it++) begin
            mem_id  = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            mem_ts  = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            wr_mode = $urandom_range(0, 1);
            extra   = ($urandom_range(0, 2) == 0);
            nm      = $sformatf("rnd%0d", it);
            base    = acc_log.size();
            pulse_start();
            if (extra) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                pulse_start();
            end
            wait_done(nm, 300, cyc);
            check_result(nm, mem_id, mem_ts, base);
        end
        wr_mode = 0;

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
